// File: rtl/mem_bus_responder.sv
// Memory-side responder for the control unit's RD/WR/ACK handshake.
// It latches each request, inserts programmable wait states, and supports abort and protocol-error reporting.
module mem_bus_responder #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     MEM_BUS_RESPONDER_CLOCK_50,
  input  logic                     MEM_BUS_RESPONDER_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_data_InBUS,
  input  logic                     MEM_BUS_RESPONDER_RD_In,
  input  logic                     MEM_BUS_RESPONDER_WR_In,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_data_OutBUS,
  output logic                     MEM_BUS_RESPONDER_ACK,
  output logic                     MEM_BUS_RESPONDER_BUSY,
  output logic                     MEM_BUS_RESPONDER_ERR
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_held;
  logic                  unused_addr_bits;

  // Upper address bits are ignored, so addresses alias modulo the array depth.
  assign req_addr         = MEM_BUS_RESPONDER_ADDRESS_InBUS[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^MEM_BUS_RESPONDER_ADDRESS_InBUS[DATAWIDTH_BUS-1:ADDR_WIDTH];
  assign req_held         = op_wr_q ? MEM_BUS_RESPONDER_WR_In : MEM_BUS_RESPONDER_RD_In;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (MEM_BUS_RESPONDER_RD_In ^ MEM_BUS_RESPONDER_WR_In) begin
          op_wr_d = MEM_BUS_RESPONDER_WR_In;
          addr_d  = req_addr;
          wdata_d = MEM_BUS_RESPONDER_data_InBUS;
          cnt_d   = WS;
          if (WS == 4'd0) begin
            state_d = S_ACK;
            // Read data is loaded on the edge into ACK so it is valid alongside ACK.
            if (MEM_BUS_RESPONDER_RD_In) rdata_d = mem_q[req_addr];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req_held) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
          if (!op_wr_q) rdata_d = mem_q[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: state_d = S_RELEASE;
      S_RELEASE: begin
        if (!MEM_BUS_RESPONDER_RD_In && !MEM_BUS_RESPONDER_WR_In) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MEM_BUS_RESPONDER_CLOCK_50 or negedge MEM_BUS_RESPONDER_RESET_InLow) begin
    if (!MEM_BUS_RESPONDER_RESET_InLow) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; a reset forces IDLE, so no write can occur mid-reset.
  always_ff @(posedge MEM_BUS_RESPONDER_CLOCK_50) begin
    if (state_q == S_ACK && op_wr_q) mem_q[addr_q] <= wdata_q;
  end

  assign MEM_BUS_RESPONDER_data_OutBUS = rdata_q;
  assign MEM_BUS_RESPONDER_ACK         = (state_q == S_ACK);
  assign MEM_BUS_RESPONDER_BUSY        = (state_q != S_IDLE);
  assign MEM_BUS_RESPONDER_ERR         = MEM_BUS_RESPONDER_RESET_InLow && (state_q == S_IDLE) &&
                                         MEM_BUS_RESPONDER_RD_In && MEM_BUS_RESPONDER_WR_In;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states and one with zero wait states.
module tb_mem_bus_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_bus, data_bus;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] dout_a, dout_b;
  logic        ack_a, busy_a, err_a, ack_b, busy_b, err_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(6), .WAIT_STATES(2)) dut_a (
    .MEM_BUS_RESPONDER_CLOCK_50     (clk),
    .MEM_BUS_RESPONDER_RESET_InLow  (rst_n),
    .MEM_BUS_RESPONDER_ADDRESS_InBUS(addr_bus),
    .MEM_BUS_RESPONDER_data_InBUS   (data_bus),
    .MEM_BUS_RESPONDER_RD_In        (rd_a),
    .MEM_BUS_RESPONDER_WR_In        (wr_a),
    .MEM_BUS_RESPONDER_data_OutBUS  (dout_a),
    .MEM_BUS_RESPONDER_ACK          (ack_a),
    .MEM_BUS_RESPONDER_BUSY         (busy_a),
    .MEM_BUS_RESPONDER_ERR          (err_a)
  );

  mem_bus_responder #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(6), .WAIT_STATES(0)) dut_b (
    .MEM_BUS_RESPONDER_CLOCK_50     (clk),
    .MEM_BUS_RESPONDER_RESET_InLow  (rst_n),
    .MEM_BUS_RESPONDER_ADDRESS_InBUS(addr_bus),
    .MEM_BUS_RESPONDER_data_InBUS   (data_bus),
    .MEM_BUS_RESPONDER_RD_In        (rd_b),
    .MEM_BUS_RESPONDER_WR_In        (wr_b),
    .MEM_BUS_RESPONDER_data_OutBUS  (dout_b),
    .MEM_BUS_RESPONDER_ACK          (ack_b),
    .MEM_BUS_RESPONDER_BUSY         (busy_b),
    .MEM_BUS_RESPONDER_ERR          (err_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input bit rd, input bit wr);
    if (sel) begin rd_b = rd; wr_b = wr; end
    else     begin rd_a = rd; wr_a = wr; end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? ack_b : ack_a;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Full handshake: drive request, wait (bounded) for ACK, check latency, release.
  task automatic xact(input bit sel, input bit is_wr, input logic [31:0] addr,
                      input logic [31:0] data, input int exp_lat, input string tag,
                      output logic [31:0] rdata);
    int  lat;
    bit  got;
    lat   = 0;
    got   = 0;
    rdata = 'x;
    @(negedge clk);
    addr_bus = addr;
    data_bus = data;
    set_req(sel, !is_wr, is_wr);
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (get_ack(sel)) begin
        got   = 1;
        rdata = sel ? dout_b : dout_a;
      end
    end
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    set_req(sel, 1'b0, 1'b0);
    @(negedge clk);
    check_val({tag, " ack_single"}, {31'd0, get_ack(sel)}, 32'd0);
    for (int i = 0; i < 5 && get_busy(sel); i++) @(negedge clk);
    check_val({tag, " release"}, {31'd0, get_busy(sel)}, 32'd0);
    $display("txn %s: sel=%0d wr=%0d addr=0x%08h data=0x%08h lat=%0d rdata=0x%08h",
             tag, sel, is_wr, addr, data, lat, rdata);
  endtask

  initial begin
    logic [31:0] rd_val;
    int          acks;
    rst_n = 1'b0; addr_bus = '0; data_bus = '0;
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    repeat (2) @(negedge clk);
    check_val("reset ack",  {31'd0, ack_a},  32'd0);
    check_val("reset busy", {31'd0, busy_a}, 32'd0);
    check_val("reset err",  {31'd0, err_a},  32'd0);
    check_val("reset data", dout_a, 32'd0);
    rst_n = 1'b1;

    // Reset during WAIT drops the write and clears outputs immediately.
    xact(0, 1, 32'd3, 32'h0000_1111, 3, "pre_w3", rd_val);
    xact(0, 0, 32'd3, 32'h0, 3, "pre_r3", rd_val);
    check_val("pre_r3 data", rd_val, 32'h0000_1111);
    @(negedge clk);
    addr_bus = 32'd3; data_bus = 32'h0000_2222; wr_a = 1;
    @(negedge clk);
    check_val("midwait busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst ack",  {31'd0, ack_a},  32'd0);
    check_val("rst busy", {31'd0, busy_a}, 32'd0);
    check_val("rst err",  {31'd0, err_a},  32'd0);
    check_val("rst data", dout_a, 32'd0);
    wr_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 0, 32'd3, 32'h0, 3, "post_rst_r3", rd_val);
    check_val("post_rst_r3 data", rd_val, 32'h0000_1111);

    // Two-wait-state write then read.
    xact(0, 1, 32'd5, 32'hDEAD_BEEF, 3, "w5", rd_val);
    check_val("w5 dout held", dout_a, 32'h0000_1111);
    xact(0, 0, 32'd5, 32'h0, 3, "r5", rd_val);
    check_val("r5 data", rd_val, 32'hDEAD_BEEF);

    // Abort: write dropped during WAIT leaves old content.
    xact(0, 1, 32'd7, 32'h0000_AAAA, 3, "w7", rd_val);
    @(negedge clk);
    addr_bus = 32'd7; data_bus = 32'h0000_1234; wr_a = 1;
    @(negedge clk);
    wr_a = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a) acks++;
    end
    check_val("abort acks", 32'(acks), 32'd0);
    check_val("abort busy", {31'd0, busy_a}, 32'd0);
    check_val("abort dout held", dout_a, 32'hDEAD_BEEF);
    xact(0, 0, 32'd7, 32'h0, 3, "r7", rd_val);
    check_val("r7 data", rd_val, 32'h0000_AAAA);

    // Both requests high in IDLE: ERR each cycle, nothing accepted.
    @(negedge clk);
    rd_a = 1; wr_a = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("both err c%0d", i),  {31'd0, err_a},  32'd1);
      check_val($sformatf("both busy c%0d", i), {31'd0, busy_a}, 32'd0);
      check_val($sformatf("both ack c%0d", i),  {31'd0, ack_a},  32'd0);
      @(negedge clk);
    end
    rd_a = 0; wr_a = 0;
    #1;
    check_val("both err clear", {31'd0, err_a}, 32'd0);
    check_val("both dout held", dout_a, 32'h0000_AAAA);
    $display("txn both_high: err seen 3 cycles");

    // Address aliasing above 2**ADDR_WIDTH.
    xact(0, 1, 32'h41, 32'h55, 3, "w41", rd_val);
    xact(0, 0, 32'h01, 32'h0, 3, "r01", rd_val);
    check_val("r01 data", rd_val, 32'h0000_0055);

    // Zero wait states: ACK the cycle after accept; held request gives one ACK.
    xact(1, 1, 32'd2, 32'h0000_0077, 1, "b_w2", rd_val);
    @(negedge clk);
    addr_bus = 32'd2; rd_b = 1;
    acks = 0;
    @(negedge clk);
    check_val("b_r2 ack first", {31'd0, ack_b}, 32'd1);
    check_val("b_r2 data", dout_b, 32'h0000_0077);
    if (ack_b) acks++;
    repeat (4) begin
      @(negedge clk);
      if (ack_b) acks++;
    end
    check_val("b_r2 ack count", 32'(acks), 32'd1);
    check_val("b_r2 busy held", {31'd0, busy_b}, 32'd1);
    rd_b = 0;
    repeat (2) @(negedge clk);
    check_val("b_r2 release", {31'd0, busy_b}, 32'd0);
    $display("txn b_r2_held: acks=%0d data=0x%08h", acks, dout_b);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end
endmodule
